// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the FIFO read-side stream adapter.
// Buffer depth and counter/pointer widths are all derived from the read latency.
package fifo_pkg;

  function automatic int buf_depth(input int rd_latency);
    return 2 + rd_latency;
  endfunction

  // Bits needed to hold a count in 0..max_count.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Small FIFO-ordered skid buffer: storage, wrapping pointers and occupancy counter.
// The oldest entry is presented combinationally on rd_data whenever valid is high.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 3,
  localparam int CNT_W  = cnt_width(DEPTH),
  localparam int PTR_W  = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              valid,
  output logic [CNT_W-1:0]  level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Depth is not a power of two for RD_LATENCY=1, so wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: storage has no reset; level gates valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= next_ptr(wr_ptr);
      if (pop)   rd_ptr <= next_ptr(rd_ptr);
      unique case ({wr_en, pop})
        2'b10:   level <= level + CNT_W'(1);
        2'b01:   level <= level - CNT_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign valid   = (level != '0);
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts a FIFO pop interface (empty/rd_req/rd_data) into a valid/ready stream.
// Reads are issued only while the skid buffer can absorb every in-flight word.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_req_o,
  input  logic [DATA_W-1:0] fifo_rd_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [1:0]        level_o
);

  localparam int BUF_DEPTH = buf_depth(RD_LATENCY);
  localparam int CNT_W     = cnt_width(BUF_DEPTH);

  logic [CNT_W-1:0] level;
  logic [CNT_W:0]   occupancy;
  logic             inflight;
  logic             capture;
  logic             armed;
  logic             rd_req;
  logic             pop;

  // Holds off requests for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // Only registered state feeds the request, so m_ready_i never reaches fifo_rd_req_o.
  assign occupancy     = {1'b0, level} + {{CNT_W{1'b0}}, inflight};
  assign rd_req        = armed && !fifo_empty_i && (occupancy < (CNT_W + 1)'(BUF_DEPTH));
  assign pop           = m_valid_o && m_ready_i;
  assign fifo_rd_req_o = rd_req;
  assign level_o       = level;

  if (RD_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) inflight <= 1'b0;
      else        inflight <= rd_req;
    end
    assign capture = inflight;
  end else if (RD_LATENCY == 0) begin : g_lat0
    assign inflight = 1'b0;
    assign capture  = rd_req;
  end else begin : g_bad_latency
    $error("fifo_rd_stream: RD_LATENCY must be 0 or 1");
  end

  stream_skid_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_skid_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (capture),
    .wr_data (fifo_rd_data_i),
    .pop     (pop),
    .rd_data (m_data_o),
    .valid   (m_valid_o),
    .level   (level)
  );

  a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
    level <= CNT_W'(BUF_DEPTH));
  a_no_capture_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(capture && level == CNT_W'(BUF_DEPTH)));
  a_no_req_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    rd_req |-> !fifo_empty_i);
  a_hold_under_backpressure: assert property (@(posedge clk) disable iff (!rst_n)
    (m_valid_o && !m_ready_i) |=> (m_valid_o && $stable(m_data_o)));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: an RD_LATENCY=0 and an RD_LATENCY=1 instance, each fed by a
// queue-based upstream FIFO model, with a scoreboard monitor comparing delivered words.
module tb_fifo_rd_stream;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          empty   [2];
  logic          rd_req  [2];
  logic [DW-1:0] rd_data [2];
  logic          valid   [2];
  logic          ready   [2];
  logic [DW-1:0] data    [2];
  logic [1:0]    level   [2];

  fifo_rd_stream #(.DATA_W(DW), .RD_LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .fifo_empty_i(empty[0]), .fifo_rd_req_o(rd_req[0]),
    .fifo_rd_data_i(rd_data[0]), .m_valid_o(valid[0]), .m_ready_i(ready[0]),
    .m_data_o(data[0]), .level_o(level[0]));

  fifo_rd_stream #(.DATA_W(DW), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .fifo_empty_i(empty[1]), .fifo_rd_req_o(rd_req[1]),
    .fifo_rd_data_i(rd_data[1]), .m_valid_o(valid[1]), .m_ready_i(ready[1]),
    .m_data_o(data[1]), .level_o(level[1]));

  logic [DW-1:0] fq    [2][$];   // upstream FIFO contents
  logic [DW-1:0] pend  [2][$];   // words written, visible from the next edge
  logic [DW-1:0] exp_q [2][$];   // scoreboard: words not yet delivered, in order
  logic          req_s [2];
  int            pops  [2];
  logic          prev_v [2];
  logic          prev_r [2];
  logic [DW-1:0] prev_d [2];
  logic [DW-1:0] w;
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic push(input int c, input logic [DW-1:0] word);
    pend[c].push_back(word);
    exp_q[c].push_back(word);
  endtask

  // Upstream FIFO model: pop on a request seen this cycle; RD_LATENCY=1 registers the data.
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rst_n && req_s[c] && fq[c].size() != 0) begin
        w = fq[c].pop_front();
        pops[c]++;
        if (c == 1) rd_data[1] <= w;
      end
      while (pend[c].size() != 0) fq[c].push_back(pend[c].pop_front());
      empty[c] <= (fq[c].size() == 0);
      if (c == 0) rd_data[0] <= (fq[0].size() != 0) ? fq[0][0] : '0;
    end
  end

  // Monitor: request legality, backpressure stability and in-order delivery.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      req_s[c] = rd_req[c];
      if (rst_n) begin
        check($sformatf("req_while_empty%0d", c), rd_req[c] && empty[c], 0);
        if (prev_v[c] && !prev_r[c]) begin
          check($sformatf("hold_valid%0d", c), valid[c], 1);
          check($sformatf("hold_data%0d", c), data[c], prev_d[c]);
        end
        if (valid[c] && ready[c]) begin
          check($sformatf("sb_word_expected%0d", c), exp_q[c].size() != 0, 1);
          if (exp_q[c].size() != 0) check($sformatf("sb_data%0d", c), data[c], exp_q[c].pop_front());
        end
        prev_v[c] = valid[c];
        prev_r[c] = ready[c];
        prev_d[c] = data[c];
      end else begin
        prev_v[c] = 1'b0;
      end
    end
  end

  task automatic wait_drain(input int c, input int limit, input string name);
    for (int i = 0; i < limit && (exp_q[c].size() != 0 || valid[c]); i++) @(negedge clk);
    check(name, exp_q[c].size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent [2];
    ready[0] = 1'b0;
    ready[1] = 1'b0;
    pops[0] = 0;
    pops[1] = 0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("rst_valid%0d", c), valid[c], 0);
      check($sformatf("rst_req%0d", c), rd_req[c], 0);
      check($sformatf("rst_level%0d", c), level[c], 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Preloaded 1..8, always ready: first word two cycles after empty falls, then one per cycle.
    #1 ready[1] = 1'b1;
    for (int i = 1; i <= 8; i++) push(1, DW'(i));
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 2) check($sformatf("lat_valid_c%0d", k), valid[1], 0);
      else begin
        check($sformatf("tp_valid_c%0d", k), valid[1], 1);
        check($sformatf("tp_data_c%0d", k), data[1], 64'(k - 1));
      end
    end
    wait_drain(1, 50, "drain_a");

    // Backpressure: three pops fill the buffer, then requests stop.
    @(posedge clk); #1 ready[1] = 1'b0;
    for (int i = 1; i <= 8; i++) push(1, DW'(i));
    sent[1] = pops[1];
    @(posedge clk);
    repeat (10) @(negedge clk);
    check("bp_pops", pops[1] - sent[1], 3);
    check("bp_level", level[1], 3);
    check("bp_valid", valid[1], 1);
    check("bp_data", data[1], 1);
    check("bp_req", rd_req[1], 0);
    @(posedge clk); #1 ready[1] = 1'b1;
    wait_drain(1, 50, "drain_b");

    // Single word then empty, refill after five cycles.
    @(posedge clk); #1 push(1, 16'h55);
    repeat (6) @(negedge clk);
    check("one_sb_empty", exp_q[1].size(), 0);
    check("one_valid", valid[1], 0);
    check("one_level", level[1], 0);
    repeat (5) @(posedge clk);
    #1 for (int i = 0; i < 3; i++) push(1, DW'(16'h60 + i));
    wait_drain(1, 50, "drain_c");

    // Random traffic on both instances, 1000 words each, ready at 50%.
    sent[0] = 0;
    sent[1] = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(posedge clk); #1;
      for (int c = 0; c < 2; c++) begin
        ready[c] = 1'($urandom_range(0, 1));
        if (sent[c] < 1000 && $urandom_range(0, 3) != 0) begin
          push(c, DW'($urandom));
          sent[c]++;
        end
      end
      if (sent[0] == 1000 && sent[1] == 1000 && exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
    end
    check("rand_sent0", sent[0], 1000);
    check("rand_drain0", exp_q[0].size(), 0);
    check("rand_drain1", exp_q[1].size(), 0);

    // Mid-operation async reset with two buffered words and one in flight.
    @(posedge clk); #1 ready[1] = 1'b0;
    for (int i = 0; i < 8; i++) push(1, DW'(16'h100 + i));
    @(posedge clk);
    for (int i = 0; i < 20 && level[1] != 2; i++) @(negedge clk);
    check("pre_rst_level", level[1], 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", valid[1], 0);
    check("arst_req", rd_req[1], 0);
    check("arst_level", level[1], 0);
    for (int c = 0; c < 2; c++) begin
      fq[c].delete();
      pend[c].delete();
      exp_q[c].delete();
    end
    for (int i = 0; i < 4; i++) push(1, DW'(16'hA0 + i));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ready[1] = 1'b1;
    @(negedge clk);
    check("req_held_after_release", rd_req[1], 0);
    @(negedge clk);
    check("req_after_arm", rd_req[1], 1);
    wait_drain(1, 50, "drain_e");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
